pipe_perf_counter: RTL and testbench

- Pipeline event monitor beside the 5-stage CPU. It consumes the hazard-unit stall/flush signals, the ID-stage branch decode and the MEM/WB retire-valid signal.
- Counts cycles, stalls, flushes, retired instructions and the longest stall run while the CPU is started.
- Offers a registered read-select port, so benches and debug logic read hardware counts instead of counting in the testbench.

---
 rtl/pipe_perf_counter.sv | 192 +++++++++++++++++++
 tb/tb_pipe_perf_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_counter.sv
// rtl/pipe_perf_counter.sv - pipeline event monitor: cycle/stall/flush/retire/max-stall-run counters
// Optional feature macro: PERF_HALT_DET_EN (idle-pipeline halt detector on halt_o).
// Ports:
//   clk_i, rst_i (async, active high)
//   start_i, stall_i, branch_i, flush_i, wb_valid_i, freeze_i, clear_i, sel_i[2:0]  inputs
//   cnt_o[CNT_W-1:0] registered selected counter, ovf_o[4:0] sticky wrap flags,
//   running_o (RUN state), halt_o (idle detect, 0 when feature not built)          outputs
module pipe_perf_counter #(
    parameter int CNT_W     = 32,
    parameter int HALT_IDLE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic             freeze_i,
    input  logic             clear_i,
    input  logic [2:0]       sel_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [4:0]       ovf_o,
    output logic             running_o,
    output logic             halt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  stl_q, stl_d;
    logic [CNT_W-1:0]  fls_q, fls_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ovf_q, ovf_d;
    logic              running_q, running_d;
    logic              count_en;
    logic              stall_ev;

`ifdef PERF_HALT_DET_EN
    localparam int                IDLE_W   = $clog2(HALT_IDLE + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HALT_IDLE);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              halt_q, halt_d;
`endif

    always_comb begin
        count_en  = (state_q == S_RUN) && !freeze_i;
        // A stall raised while a branch is decoded is branch resolution, not a data hazard.
        stall_ev  = stall_i && !branch_i;

        state_d   = state_q;
        cyc_d     = cyc_q;
        stl_d     = stl_q;
        fls_d     = fls_q;
        ret_d     = ret_q;
        max_d     = max_q;
        run_d     = run_q;
        ovf_d     = ovf_q;

        // start_i low wins over freeze_i from both RUN and HOLD.
        case (state_q)
            S_IDLE:  state_d = start_i ? S_RUN : S_IDLE;
            S_RUN:   state_d = !start_i ? S_IDLE : (freeze_i ? S_HOLD : S_RUN);
            S_HOLD:  state_d = !start_i ? S_IDLE : (freeze_i ? S_HOLD : S_RUN);
            default: state_d = S_IDLE;
        endcase

        // Readout uses pre-update values, giving one cycle of latency.
        case (sel_i)
            3'd0:    cnt_d = cyc_q;
            3'd1:    cnt_d = stl_q;
            3'd2:    cnt_d = fls_q;
            3'd3:    cnt_d = ret_q;
            3'd4:    cnt_d = max_q;
            default: cnt_d = '0;
        endcase

        if (count_en) begin
            cyc_d = cyc_q + ONE;
            if (cyc_q == ONES) ovf_d[0] = 1'b1;
            if (flush_i) begin
                fls_d = fls_q + ONE;
                if (fls_q == ONES) ovf_d[2] = 1'b1;
            end
            if (wb_valid_i) begin
                ret_d = ret_q + ONE;
                if (ret_q == ONES) ovf_d[3] = 1'b1;
            end
            if (stall_ev) begin
                stl_d = stl_q + ONE;
                if (stl_q == ONES) ovf_d[1] = 1'b1;
                // Run length saturates; a run that outgrows the counter flags ovf[4].
                if (run_q == ONES) begin
                    max_d    = ONES;
                    ovf_d[4] = 1'b1;
                end else begin
                    run_d = run_q + ONE;
                    if (run_d > max_q) max_d = run_d;
                end
            end else begin
                run_d = '0;
            end
        end

        if (state_d == S_IDLE) run_d = '0;

        running_d = (state_d == S_RUN);

`ifdef PERF_HALT_DET_EN
        idle_d = idle_q;
        halt_d = halt_q;
        if (count_en) begin
            if (wb_valid_i) begin
                idle_d = '0;
            end else begin
                if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
                if ((idle_d == IDLE_MAX) && (ret_q != '0)) halt_d = 1'b1;
            end
        end
`endif

        if (clear_i) begin
            cyc_d = '0;
            stl_d = '0;
            fls_d = '0;
            ret_d = '0;
            max_d = '0;
            run_d = '0;
            ovf_d = '0;
            cnt_d = '0;
`ifdef PERF_HALT_DET_EN
            idle_d = '0;
            halt_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            stl_q     <= '0;
            fls_q     <= '0;
            ret_q     <= '0;
            max_q     <= '0;
            run_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            running_q <= 1'b0;
`ifdef PERF_HALT_DET_EN
            idle_q    <= '0;
            halt_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stl_q     <= stl_d;
            fls_q     <= fls_d;
            ret_q     <= ret_d;
            max_q     <= max_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
`ifdef PERF_HALT_DET_EN
            idle_q    <= idle_d;
            halt_q    <= halt_d;
`endif
        end
    end

    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;
    assign running_o = running_q;
`ifdef PERF_HALT_DET_EN
    assign halt_o    = halt_q;
`else
    assign halt_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_perf_counter.sv
// tb/tb_pipe_perf_counter.sv - self-checking bench for pipe_perf_counter (32-bit and 4-bit instances)
module tb_pipe_perf_counter;

    localparam int WA = 32;
    localparam int WB = 4;
    localparam int HI = 4;
    localparam longint MASKA = (64'd1 << WA) - 1;
    localparam longint MASKB = (64'd1 << WB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0;
    logic wbv = 1'b0, freeze = 1'b0, clear = 1'b0;
    logic [2:0] sel = 3'd0;

    logic [WA-1:0] cnt_a;
    logic [WB-1:0] cnt_b;
    logic [4:0]    ovf_a, ovf_b;
    logic          run_a, run_b, halt_a, halt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_perf_counter #(.CNT_W(WA), .HALT_IDLE(HI)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .wb_valid_i(wbv), .freeze_i(freeze), .clear_i(clear), .sel_i(sel),
        .cnt_o(cnt_a), .ovf_o(ovf_a), .running_o(run_a), .halt_o(halt_a)
    );

    pipe_perf_counter #(.CNT_W(WB), .HALT_IDLE(HI)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .wb_valid_i(wbv), .freeze_i(freeze), .clear_i(clear), .sel_i(sel),
        .cnt_o(cnt_b), .ovf_o(ovf_b), .running_o(run_b), .halt_o(halt_b)
    );

    // Model: unbounded event totals since the last clear/reset; each instance's view is
    // derived by reducing them to its width (mod for counts, min for the run maximum).
    longint m_cnt [5];
    longint m_run, m_idle, m_rd, m_prev_ret;
    int     m_state, m_nxt, m_rd_sel;
    bit     m_cen, m_halt_a, m_halt_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_run = 0; m_idle = 0; m_state = 0; m_rd = 0; m_rd_sel = 0;
            m_halt_a = 0; m_halt_b = 0;
        end else begin
            m_cen = (m_state == 1) && !freeze;
            if (m_state == 0)  m_nxt = start ? 1 : 0;
            else if (!start)   m_nxt = 0;
            else               m_nxt = freeze ? 2 : 1;
            m_rd_sel = int'(sel);
            m_rd     = (clear || sel > 3'd4) ? 0 : m_cnt[sel];
            if (clear) begin
                for (int i = 0; i < 5; i++) m_cnt[i] = 0;
                m_run = 0; m_idle = 0; m_halt_a = 0; m_halt_b = 0;
            end else if (m_cen) begin
                m_cnt[0]++;
                if (stall && !branch) begin
                    m_cnt[1]++;
                    m_run++;
                    if (m_run > m_cnt[4]) m_cnt[4] = m_run;
                end else begin
                    m_run = 0;
                end
                if (flush) m_cnt[2]++;
                m_prev_ret = m_cnt[3];
                if (wbv) begin
                    m_cnt[3]++;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle >= HI && (m_prev_ret & MASKA) != 0) m_halt_a = 1;
                    if (m_idle >= HI && (m_prev_ret & MASKB) != 0) m_halt_b = 1;
                end
            end
            if (m_nxt == 0) m_run = 0;
            m_state = m_nxt;
        end
    end

    function automatic longint exp_cnt(input longint mask);
        if (m_rd_sel == 4) return (m_rd > mask) ? mask : m_rd;
        return m_rd & mask;
    endfunction

    function automatic logic [4:0] exp_ovf(input longint mask);
        logic [4:0] e;
        for (int i = 0; i < 5; i++) e[i] = (m_cnt[i] > mask);
        return e;
    endfunction

    function automatic bit exp_halt(input bit h);
`ifdef PERF_HALT_DET_EN
        return h;
`else
        return 1'b0 & h;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("m_cnt_a", 64'(cnt_a), 64'(exp_cnt(MASKA)));
            check("m_cnt_b", 64'(cnt_b), 64'(exp_cnt(MASKB)));
            check("m_ovf_a", 64'(ovf_a), 64'(exp_ovf(MASKA)));
            check("m_ovf_b", 64'(ovf_b), 64'(exp_ovf(MASKB)));
            check("m_run_a", 64'(run_a), 64'(m_state == 1));
            check("m_run_b", 64'(run_b), 64'(m_state == 1));
            check("m_halt_a", 64'(halt_a), 64'(exp_halt(m_halt_a)));
            check("m_halt_b", 64'(halt_b), 64'(exp_halt(m_halt_b)));
        end
    end

    task automatic step(input bit st, input bit sv, input bit br, input bit fl,
                        input bit wb, input bit fr, input bit cl, input logic [2:0] sl);
        start = st; stall = sv; branch = br; flush = fl;
        wbv = wb; freeze = fr; clear = cl; sel = sl;
        @(posedge clk);
        #1;
    endtask

    // Leave RUN without a counting edge and latch the selected counter.
    task automatic read_sel(input logic [2:0] sl);
        step(0, 0, 0, 0, 0, 1, 0, sl);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        check("reset_cnt", 64'(cnt_a), 64'd0);
        check("reset_ovf", 64'(ovf_a), 64'd0);
        check("reset_running", 64'(run_a), 64'd0);
        check("reset_halt", 64'(halt_a), 64'd0);

        // Reset mid-RUN: outputs drop without a clock edge.
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 1, 0, 0, 3'd0);
        check("midrun_running_pre", 64'(run_a), 64'd1);
        check("midrun_cnt_pre", 64'(cnt_a), 64'd9);
        #1 rst = 1'b1;
        #1;
        check("midrun_cnt", 64'(cnt_a), 64'd0);
        check("midrun_ovf", 64'(ovf_b), 64'd0);
        check("midrun_running", 64'(run_a), 64'd0);
        #1 rst = 1'b0;

        // Stall/flush/retire mix over 20 counting edges.
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 20; i++)
            step(1, (i >= 2 && i <= 4), (i == 3), (i == 4 || i == 9), (i < 12), 0, 0, 3'd0);
        read_sel(3'd3);
        check("latency_sel3_retired", 64'(cnt_a), 64'd12);
        read_sel(3'd0);
        check("mix_cycles", 64'(cnt_a), 64'd20);
        read_sel(3'd1);
        check("mix_stalls", 64'(cnt_a), 64'd2);
        read_sel(3'd2);
        check("mix_flushes", 64'(cnt_a), 64'd2);
        read_sel(3'd6);
        check("reserved_sel6", 64'(cnt_a), 64'd0);
        check("idle_running", 64'(run_a), 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 3'd0);

        // Stall runs 2, 5 (frozen in the middle), 3.
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 0, 0, 0, 3'd0); step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 0, 0, 0, 3'd0); step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 0, 1, 0, 3'd0); step(1, 1, 0, 0, 0, 1, 0, 3'd0);
        check("hold_running", 64'(run_a), 64'd0);
        step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 0, 0, 0, 3'd0); step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        read_sel(3'd4);
        check("max_stall_run", 64'(cnt_a), 64'd5);
        read_sel(3'd1);
        check("run_total_stalls", 64'(cnt_a), 64'd10);
        step(0, 0, 0, 0, 0, 0, 1, 3'd0);

        // Wrap on the 4-bit instance, then clear against an active stall.
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        read_sel(3'd0);
        check("wrap_cycles_b", 64'(cnt_b), 64'd1);
        check("wrap_ovf0_b", 64'(ovf_b[0]), 64'd1);
        check("nowrap_cycles_a", 64'(cnt_a), 64'd17);
        step(1, 0, 0, 0, 0, 0, 0, 3'd1);
        step(1, 1, 0, 0, 0, 0, 1, 3'd1);
        check("clear_cnt_b", 64'(cnt_b), 64'd0);
        check("clear_ovf_b", 64'(ovf_b), 64'd0);
        read_sel(3'd1);
        check("clear_stalls_b", 64'(cnt_b), 64'd0);

        // Idle-pipeline halt detect.
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 3'd0);
        check("halt_after3", 64'(halt_a), 64'd0);
        step(1, 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef PERF_HALT_DET_EN
        check("halt_after4", 64'(halt_a), 64'd1);
        step(1, 0, 0, 0, 1, 0, 0, 3'd0);
        check("halt_sticky", 64'(halt_a), 64'd1);
`else
        check("halt_tied_low", 64'(halt_a), 64'd0);
        step(1, 0, 0, 0, 1, 0, 0, 3'd0);
`endif
        read_sel(3'd0);
        step(0, 0, 0, 0, 0, 0, 1, 3'd0);
        check("halt_cleared", 64'(halt_a), 64'd0);

        // Randomized traffic, with periodic long stall bursts and async resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 < 24) begin
                step(1, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0,
                     3'($urandom_range(0, 7)));
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)));
            end
            if (i % 500 == 250) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
